// File: rtl/tx_fcs_controller.sv
// Transmit-path FCS sequencer: passes frame bytes through to the PHY side and the CRC engine,
// zero-pads short frames, appends the engine's 32-bit result, then holds off for the inter-frame gap.
module tx_fcs_controller #(
  parameter int MIN_LEN     = 60,
  parameter int IFG_CYCLES  = 12,
  parameter int CRC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  crc_data,
  output logic        crc_data_valid,
  output logic        crc_en,
  input  logic [31:0] crc_result,
  input  logic        crc_done,
  output logic        busy,
  output logic        err_timeout
);

  localparam int CNT_W  = 11;
  localparam int WAIT_W = $clog2(CRC_TIMEOUT + 1);
  localparam int IFG_W  = $clog2(IFG_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W:0]    MIN_LEN_W = (CNT_W + 1)'(MIN_LEN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CRC_TIMEOUT - 1);
  localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD,
    S_WAIT_CRC,
    S_FCS,
    S_IFG
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  byte_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [IFG_W-1:0]  ifg_cnt_reg;
  logic [1:0]        fcs_idx_reg;
  logic [31:0]       fcs_reg;
  logic              err_timeout_reg;
  logic              in_reset_reg;

  logic [7:0]       fcs_bytes [4];
  logic             xfer;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fcs_byte
      assign fcs_bytes[gi] = fcs_reg[8*gi +: 8];
    end
  endgenerate

  // The counter is stale in IDLE until the first byte lands, so count from zero there.
  assign cnt_base = (state_reg == S_IDLE) ? '0 : byte_cnt_reg;
  assign cnt_inc  = {1'b0, cnt_base} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat  = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_inc[CNT_W-1:0];

  // Outputs stay at their reset values for the cycle after reset is sampled.
  always_comb begin
    in_ready       = 1'b0;
    out_data       = 8'h00;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    crc_data       = 8'h00;
    crc_data_valid = 1'b0;
    crc_en         = 1'b0;
    if (!in_reset_reg) begin
      case (state_reg)
        S_IDLE: begin
          in_ready       = out_ready;
          out_data       = in_data;
          out_valid      = in_valid;
          crc_data       = in_data;
          crc_data_valid = in_valid && out_ready;
          crc_en         = in_valid && out_ready;
        end
        S_DATA: begin
          in_ready       = out_ready;
          out_data       = in_data;
          out_valid      = in_valid;
          crc_data       = in_data;
          crc_data_valid = in_valid && out_ready;
          crc_en         = 1'b1;
        end
        S_PAD: begin
          out_valid      = 1'b1;
          crc_data_valid = out_ready;
          crc_en         = 1'b1;
        end
        S_FCS: begin
          out_data  = fcs_bytes[fcs_idx_reg];
          out_valid = 1'b1;
          out_last  = (fcs_idx_reg == 2'd3);
        end
        default: begin
        end
      endcase
    end
  end

  assign xfer        = out_valid && out_ready;
  assign busy        = (state_reg != S_IDLE);
  assign err_timeout = err_timeout_reg;

  always_ff @(posedge clk) begin
    in_reset_reg    <= rst;
    err_timeout_reg <= 1'b0;
    if (rst) begin
      state_reg    <= S_IDLE;
      byte_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      ifg_cnt_reg  <= '0;
      fcs_idx_reg  <= '0;
      fcs_reg      <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          byte_cnt_reg <= '0;
          if (xfer) begin
            byte_cnt_reg <= cnt_sat;
            if (!in_last) begin
              state_reg <= S_DATA;
            end else if (cnt_inc < MIN_LEN_W) begin
              state_reg <= S_PAD;
            end else begin
              state_reg    <= S_WAIT_CRC;
              wait_cnt_reg <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            byte_cnt_reg <= cnt_sat;
            if (in_last) begin
              if (cnt_inc < MIN_LEN_W) begin
                state_reg <= S_PAD;
              end else begin
                state_reg    <= S_WAIT_CRC;
                wait_cnt_reg <= '0;
              end
            end
          end
        end
        S_PAD: begin
          if (xfer) begin
            byte_cnt_reg <= cnt_sat;
            if (cnt_inc >= MIN_LEN_W) begin
              state_reg    <= S_WAIT_CRC;
              wait_cnt_reg <= '0;
            end
          end
        end
        S_WAIT_CRC: begin
          // A done on the final count still wins over the timeout.
          if (crc_done) begin
            fcs_reg     <= crc_result;
            fcs_idx_reg <= '0;
            state_reg   <= S_FCS;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            err_timeout_reg <= 1'b1;
            ifg_cnt_reg     <= '0;
            state_reg       <= S_IFG;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        S_FCS: begin
          if (xfer) begin
            if (fcs_idx_reg == 2'd3) begin
              ifg_cnt_reg <= '0;
              state_reg   <= S_IFG;
            end else begin
              fcs_idx_reg <= fcs_idx_reg + 1'b1;
            end
          end
        end
        S_IFG: begin
          if (ifg_cnt_reg == IFG_LAST) begin
            state_reg <= S_IDLE;
          end else begin
            ifg_cnt_reg <= ifg_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
